// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types, defaults and width helper for the SPI receiver
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } rx_state_t;

    localparam int DATA_W_DEF      = 8;
    localparam int SYNC_STAGES_DEF = 2;

    // bit counter must hold DATA_W itself, not just DATA_W-1
    function automatic int cnt_width(input int data_w);
        return $clog2(data_w) + 1;
    endfunction

endpackage

// File: rtl/spi_rx_if.sv
// rtl/spi_rx_if.sv - received-word handshake between spi_rx and its consumer
interface spi_rx_if
    import spi_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);

    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ack;
    logic              frame_err;
    logic              overrun;

    modport slave (
        output rx_data, rx_valid, frame_err, overrun,
        input  rx_ack
    );

    modport master (
        input  rx_data, rx_valid, frame_err, overrun,
        output rx_ack
    );

endinterface

// File: rtl/spi_edge_sync.sv
// rtl/spi_edge_sync.sv - pin synchronizer chain with history flop and edge detect
module spi_edge_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   hist;

    // shift the async pin through the chain; hist keeps the previous synced value
    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= {SYNC_STAGES{RESET_VAL}};
            hist  <= RESET_VAL;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], pin};
            hist  <= chain[SYNC_STAGES-1];
        end
    end

    assign sync = chain[SYNC_STAGES-1];
    assign rise = sync & ~hist;
    assign fall = ~sync & hist;

endmodule

// File: rtl/spi_rx.sv
// rtl/spi_rx.sv - SPI mode-0 responder receiver; SPI_RX_MISO_EN adds the miso transmit path
module spi_rx
    import spi_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
`ifdef SPI_RX_MISO_EN
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_load,
    output logic              miso,
`endif
    spi_rx_if.slave           rx
);

    localparam int CNT_W = cnt_width(DATA_W);

    logic sclk_sync_unused, sclk_rise, sclk_fall;
    logic cs_sync, cs_rise, cs_fall_unused;
    logic mosi_sync, mosi_rise_unused, mosi_fall_unused;

    // mosi uses the same depth as sclk so its setup/hold against sclk survives
    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk (
        .clk(clk), .rst(rst), .pin(sclk),
        .sync(sclk_sync_unused), .rise(sclk_rise), .fall(sclk_fall)
    );
    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs (
        .clk(clk), .rst(rst), .pin(cs_n),
        .sync(cs_sync), .rise(cs_rise), .fall(cs_fall_unused)
    );
    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_mosi (
        .clk(clk), .rst(rst), .pin(mosi),
        .sync(mosi_sync), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    rx_state_t         state, state_d;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shreg;
    logic              pending;
    logic              do_start, do_shift, do_abort, do_done;

    // next-state and per-cycle control strobes; cs_n rise takes priority over sclk rise
    always_comb begin
        state_d  = state;
        do_start = 1'b0;
        do_shift = 1'b0;
        do_abort = 1'b0;
        do_done  = 1'b0;
        case (state)
            IDLE: begin
                if (!cs_sync) begin
                    state_d  = SHIFT;
                    do_start = 1'b1;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    state_d  = IDLE;
                    do_abort = (bit_cnt != '0);
                end else if (sclk_rise) begin
                    do_shift = 1'b1;
                    if (bit_cnt == CNT_W'(DATA_W - 1))
                        state_d = DONE;
                end
            end
            DONE: begin
                do_done = 1'b1;
                state_d = cs_sync ? IDLE : SHIFT;
            end
            default: state_d = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_d;
    end

    // datapath: shifter, bit counter, word output and pending/overrun flags
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt      <= '0;
            shreg        <= '0;
            pending      <= 1'b0;
            rx.rx_data   <= '0;
            rx.rx_valid  <= 1'b0;
            rx.frame_err <= 1'b0;
            rx.overrun   <= 1'b0;
        end else begin
            rx.rx_valid  <= do_done;
            rx.frame_err <= do_abort;
            if (do_start || do_done || do_abort)
                bit_cnt <= '0;
            else if (do_shift)
                bit_cnt <= bit_cnt + 1'b1;
            if (do_shift)
                shreg <= {shreg[DATA_W-2:0], mosi_sync};
            if (do_done)
                rx.rx_data <= shreg;
            // an ack landing in DONE retires the old word; the new one stays pending
            if (do_done)
                pending <= 1'b1;
            else if (rx.rx_ack)
                pending <= 1'b0;
            if (rx.rx_ack)
                rx.overrun <= 1'b0;
            else if (do_done && pending)
                rx.overrun <= 1'b1;
        end
    end

`ifdef SPI_RX_MISO_EN
    logic [DATA_W-1:0] tx_sr;
    logic              tx_loaded;
    logic              skip_fall;

    // the fall right after a word's last rise belongs to the next word, whose MSB is already out
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_sr     <= '1;
            tx_loaded <= 1'b0;
            skip_fall <= 1'b0;
        end else if (state == IDLE) begin
            if (tx_load) begin
                tx_sr     <= tx_data;
                tx_loaded <= 1'b1;
            end
            if (do_start) begin
                if (!tx_loaded && !tx_load)
                    tx_sr <= '1;
                tx_loaded <= 1'b0;
                skip_fall <= 1'b0;
            end
        end else if (do_done) begin
            tx_sr     <= tx_load ? tx_data : '1;
            skip_fall <= 1'b1;
        end else if (state == SHIFT && sclk_fall) begin
            if (skip_fall)
                skip_fall <= 1'b0;
            else
                tx_sr <= {tx_sr[DATA_W-2:0], 1'b1};
        end
    end

    assign miso = cs_sync ? 1'b0 : tx_sr[DATA_W-1];
`else
    logic sclk_fall_unused;
    assign sclk_fall_unused = sclk_fall;
`endif

endmodule

// File: tb/tb_spi_rx.sv
// tb/tb_spi_rx.sv - self-checking bench for spi_rx
module tb_spi_rx;
    import spi_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sclk = 1'b0;
    logic cs_n = 1'b1;
    logic mosi = 1'b0;
`ifdef SPI_RX_MISO_EN
    logic [7:0] tx_data = 8'h00;
    logic       tx_load = 1'b0;
    logic       miso;
    logic [7:0] miso_cap = 8'h00;
`endif

    spi_rx_if #(.DATA_W(8)) ifc ();

    spi_rx #(.DATA_W(8), .SYNC_STAGES(2)) dut (
        .clk(clk),
        .rst(rst),
        .sclk(sclk),
        .cs_n(cs_n),
        .mosi(mosi),
`ifdef SPI_RX_MISO_EN
        .tx_data(tx_data),
        .tx_load(tx_load),
        .miso(miso),
`endif
        .rx(ifc)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // reference model: words in completion order with expected overrun at valid time
    typedef struct {
        logic [7:0] data;
        logic       ovr;
        bit         ack;
    } exp_t;

    exp_t exp_q[$];
    bit   m_pend = 1'b0;
    bit   m_ovr  = 1'b0;
    int   n_valid = 0;
    int   n_ferr  = 0;

    function automatic logic model_step(input bit ack);
        logic o;
        o = m_ovr | m_pend;
        m_pend = 1'b1;
        m_ovr  = o;
        if (ack) begin
            m_pend = 1'b0;
            m_ovr  = 1'b0;
        end
        return o;
    endfunction

    task automatic push_word(input logic [7:0] w, input bit ack, input logic ovr);
        exp_t e;
        e.data = w;
        e.ovr  = ovr;
        e.ack  = ack;
        exp_q.push_back(e);
    endtask

    bit ack_auto = 1'b0;
    bit man_ack  = 1'b0;
    assign ifc.rx_ack = ack_auto | man_ack;

    // monitor: score each rx_valid against the model, ack on request, count frame_err
    always @(negedge clk) begin
        exp_t e;
        if (ack_auto)
            ack_auto = 1'b0;
        if (!rst) begin
            if (ifc.frame_err)
                n_ferr++;
            if (ifc.rx_valid) begin
                n_valid++;
                check("valid_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("rx_data", ifc.rx_data, e.data);
                    check("overrun_at_valid", ifc.overrun, e.ovr);
                    if (e.ack)
                        ack_auto = 1'b1;
                end
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cs_begin();
        @(negedge clk);
        cs_n = 1'b0;
        wait_clk(4);
    endtask

    task automatic cs_end();
        wait_clk(4);
        cs_n = 1'b1;
        wait_clk(12);
    endtask

    // master side, sclk = clk/8, MSB first; miso sampled just before each rise
    task automatic send_bits(input logic [7:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            mosi = w[7-i];
            wait_clk(4);
`ifdef SPI_RX_MISO_EN
            miso_cap = {miso_cap[6:0], miso};
`endif
            sclk = 1'b1;
            wait_clk(4);
            sclk = 1'b0;
        end
    endtask

    typedef struct {
        logic [7:0] word;
        bit         ack;
        bit         join_next;
        logic       exp_ovr;
    } vec_t;

    vec_t tbl[7];

    initial begin
        bit in_win;
        int v0, f0;
        logic o;
        logic [7:0] w;
        bit ack, jn;

        tbl[0] = '{8'hA5, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{8'h3C, 1'b1, 1'b1, 1'b0};
        tbl[2] = '{8'hC3, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{8'h11, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{8'h22, 1'b0, 1'b0, 1'b1};
        tbl[5] = '{8'h33, 1'b1, 1'b0, 1'b1};
        tbl[6] = '{8'h5A, 1'b1, 1'b0, 1'b0};

        wait_clk(3);
        check("rst_rx_data", ifc.rx_data, 0);
        check("rst_rx_valid", ifc.rx_valid, 0);
        check("rst_frame_err", ifc.frame_err, 0);
        check("rst_overrun", ifc.overrun, 0);
`ifdef SPI_RX_MISO_EN
        check("rst_miso", miso, 0);
`endif
        rst = 1'b0;
        wait_clk(4);

        // table-driven frames
        in_win = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (!in_win)
                cs_begin();
            void'(model_step(tbl[i].ack));
            push_word(tbl[i].word, tbl[i].ack, tbl[i].exp_ovr);
            send_bits(tbl[i].word, 8);
            if (tbl[i].join_next) begin
                in_win = 1'b1;
            end else begin
                cs_end();
                in_win = 1'b0;
                check("tbl_drained", exp_q.size(), 0);
                check("tbl_overrun_after", ifc.overrun, m_ovr);
            end
        end
        check("tbl_valid_count", n_valid, 7);
        check("tbl_no_frame_err", n_ferr, 0);

        // aborted frame: 5 bits then cs_n high
        v0 = n_valid;
        f0 = n_ferr;
        cs_begin();
        send_bits(8'hFF, 5);
        cs_end();
        check("abort_frame_err", n_ferr, f0 + 1);
        check("abort_no_valid", n_valid, v0);
        check("abort_rx_data_held", ifc.rx_data, 8'h5A);
        cs_begin();
        o = model_step(1'b1);
        push_word(8'h7E, 1'b1, o);
        send_bits(8'h7E, 8);
        cs_end();
        check("after_abort_rx_data", ifc.rx_data, 8'h7E);

        // sclk rise and cs_n rise in the same cycle: cs_n wins
        v0 = n_valid;
        f0 = n_ferr;
        cs_begin();
        send_bits(8'h00, 7);
        mosi = 1'b1;
        wait_clk(4);
        sclk = 1'b1;
        cs_n = 1'b1;
        wait_clk(4);
        sclk = 1'b0;
        wait_clk(12);
        check("simul_frame_err", n_ferr, f0 + 1);
        check("simul_no_valid", n_valid, v0);

        // sclk toggling with cs_n high is ignored
        for (int i = 0; i < 10; i++) begin
            mosi = i[0];
            wait_clk(4);
            sclk = 1'b1;
            wait_clk(4);
            sclk = 1'b0;
        end
        wait_clk(8);
        check("cs_high_no_valid", n_valid, v0);
        check("cs_high_no_ferr", n_ferr, f0 + 1);
        cs_begin();
        o = model_step(1'b1);
        push_word(8'hC6, 1'b1, o);
        send_bits(8'hC6, 8);
        cs_end();
        check("after_ignored_rx_data", ifc.rx_data, 8'hC6);

        // reset mid-frame after 3 bits
        f0 = n_ferr;
        cs_begin();
        send_bits(8'hFF, 3);
        rst  = 1'b1;
        cs_n = 1'b1;
        wait_clk(2);
        check("midrst_rx_data", ifc.rx_data, 0);
        check("midrst_overrun", ifc.overrun, 0);
        rst = 1'b0;
        m_pend = 1'b0;
        m_ovr  = 1'b0;
        wait_clk(6);
        cs_begin();
        o = model_step(1'b1);
        push_word(8'h81, 1'b1, o);
        send_bits(8'h81, 8);
        cs_end();
        check("midrst_after_rx_data", ifc.rx_data, 8'h81);
        check("midrst_no_ferr", n_ferr, f0);

        // randomized words, random acks and random cs_n windows
        in_win = 1'b0;
        for (int i = 0; i < 24; i++) begin
            w   = 8'($urandom);
            ack = ($urandom_range(0, 3) != 0);
            jn  = (i != 23) && ($urandom_range(0, 2) == 0);
            if (!in_win)
                cs_begin();
            o = model_step(ack);
            push_word(w, ack, o);
            send_bits(w, 8);
            if (jn) begin
                in_win = 1'b1;
            end else begin
                cs_end();
                in_win = 1'b0;
                check("rand_overrun_after", ifc.overrun, m_ovr);
            end
        end
        check("rand_drained", exp_q.size(), 0);

`ifdef SPI_RX_MISO_EN
        // miso: loaded word in the first frame, all-ones when nothing was loaded
        @(negedge clk);
        tx_data = 8'h96;
        tx_load = 1'b1;
        wait_clk(1);
        tx_load = 1'b0;
        cs_begin();
        o = model_step(1'b1);
        push_word(8'h00, 1'b1, o);
        send_bits(8'h00, 8);
        cs_end();
        check("miso_loaded", miso_cap, 8'h96);
        check("miso_rx_data", ifc.rx_data, 8'h00);
        cs_begin();
        o = model_step(1'b1);
        push_word(8'h00, 1'b1, o);
        send_bits(8'h00, 8);
        cs_end();
        check("miso_default_ones", miso_cap, 8'hFF);
        check("miso_idle_low", miso, 0);
`endif

        wait_clk(20);
        check("final_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        failures++;
        $display("FAIL watchdog timeout");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
